// File: rtl/dbgapb_mst.sv
// dbgapb_mst: expands one debug command into APB transfers to the debug window.
// Define DBGAPB_MST_TIMEOUT_EN to bound the ACCESS wait on pready by TIMEOUT.
module dbgapb_mst #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [11:0] OFS_DBG_EN   = 12'h000,
  parameter logic [11:0] OFS_INST     = 12'h004,
  parameter logic [11:0] OFS_INST_WR  = 12'h008,
  parameter logic [11:0] OFS_WDATA    = 12'h00c,
  parameter logic [11:0] OFS_WDATA_WR = 12'h010,
  parameter logic [11:0] OFS_RDATA    = 12'h014
`ifdef DBGAPB_MST_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT      = 1023
`endif
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_inst,
  input  logic [31:0] cmd_wdata,
  input  logic        cmd_wr,
  input  logic        cmd_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [3:0]  pstrb,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [2:0] ST_EN    = 3'd0;
  localparam logic [2:0] ST_WD    = 3'd1;
  localparam logic [2:0] ST_WDWR  = 3'd2;
  localparam logic [2:0] ST_INST  = 3'd3;
  localparam logic [2:0] ST_INSWR = 3'd4;
  localparam logic [2:0] ST_RD    = 3'd5;

  state_t      r_state, w_state;
  logic [2:0]  r_step, w_step, w_ld_step;
  logic [5:0]  r_todo, w_todo, w_mask;
  logic [31:0] r_inst, w_inst, w_ld_inst;
  logic [31:0] r_wdata, w_wdata, w_ld_wdata;
  logic        r_en_done, w_en_done;
  logic        r_psel, w_psel, r_penable, w_penable;
  logic        r_pwrite, w_pwrite;
  logic [31:0] r_paddr, w_paddr, r_pwdata, w_pwdata;
  logic [3:0]  r_pstrb, w_pstrb;
  logic        r_rsp_valid, w_rsp_valid, r_rsp_err, w_rsp_err;
  logic [31:0] r_rsp_rdata, w_rsp_rdata;
  logic        w_load, w_finish, w_abort;

  function automatic logic [2:0] f_first(input logic [5:0] m);
    f_first = 3'd0;
    for (int i = 5; i >= 0; i--)
      if (m[i]) f_first = 3'(i);
  endfunction

  function automatic logic [5:0] f_bit(input logic [2:0] s);
    f_bit = 6'b1 << s;
  endfunction

  function automatic logic [11:0] f_ofs(input logic [2:0] s);
    case (s)
      ST_EN:    f_ofs = OFS_DBG_EN;
      ST_WD:    f_ofs = OFS_WDATA;
      ST_WDWR:  f_ofs = OFS_WDATA_WR;
      ST_INST:  f_ofs = OFS_INST;
      ST_INSWR: f_ofs = OFS_INST_WR;
      default:  f_ofs = OFS_RDATA;
    endcase
  endfunction

  function automatic logic [31:0] f_data(input logic [2:0]  s,
                                         input logic [31:0] inst,
                                         input logic [31:0] wd);
    case (s)
      ST_WD:   f_data = wd;
      ST_INST: f_data = inst;
      ST_RD:   f_data = 32'h0;
      default: f_data = 32'h1;
    endcase
  endfunction

`ifdef DBGAPB_MST_TIMEOUT_EN
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);
  logic [9:0] r_tmo;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)
      r_tmo <= '0;
    else if (r_state == SETUP)
      r_tmo <= '0;
    else if (r_state == ACCESS && !pready)
      r_tmo <= r_tmo + 10'd1;
  end
`endif

  always_comb begin
    w_state     = r_state;
    w_step      = r_step;
    w_todo      = r_todo;
    w_inst      = r_inst;
    w_wdata     = r_wdata;
    w_en_done   = r_en_done;
    w_psel      = r_psel;
    w_penable   = r_penable;
    w_pwrite    = r_pwrite;
    w_paddr     = r_paddr;
    w_pstrb     = r_pstrb;
    w_pwdata    = r_pwdata;
    w_rsp_valid = r_rsp_valid;
    w_rsp_err   = r_rsp_err;
    w_rsp_rdata = r_rsp_rdata;
    w_load      = 1'b0;
    w_finish    = 1'b0;
    w_abort     = 1'b0;
    w_ld_step   = r_step;
    w_ld_inst   = r_inst;
    w_ld_wdata  = r_wdata;
    // bit i of the mask enables step i, in issue order
    w_mask = {cmd_rd, 2'b11, cmd_wr, cmd_wr, ~r_en_done};
    unique case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_inst      = cmd_inst;
          w_wdata     = cmd_wdata;
          w_rsp_rdata = '0;
          w_rsp_err   = 1'b0;
          w_load      = 1'b1;
          w_ld_step   = f_first(w_mask);
          w_ld_inst   = cmd_inst;
          w_ld_wdata  = cmd_wdata;
          w_todo      = w_mask & ~f_bit(w_ld_step);
        end
      end
      SETUP: begin
        w_penable = 1'b1;
        w_state   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          if (pslverr) begin
            w_abort = 1'b1;
          end else begin
            if (r_step == ST_EN) w_en_done = 1'b1;
            if (r_step == ST_RD) w_rsp_rdata = prdata;
            if (r_todo == '0) begin
              w_finish = 1'b1;
            end else begin
              w_load    = 1'b1;
              w_ld_step = f_first(r_todo);
              w_todo    = r_todo & ~f_bit(w_ld_step);
            end
          end
        end
`ifdef DBGAPB_MST_TIMEOUT_EN
        else if (r_tmo == TMO_LAST) begin
          w_abort = 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_state     = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
    if (w_abort) begin
      w_rsp_err   = 1'b1;
      w_rsp_rdata = '0;
      w_finish    = 1'b1;
    end
    if (w_finish) begin
      w_state     = RESP;
      w_psel      = 1'b0;
      w_penable   = 1'b0;
      w_rsp_valid = 1'b1;
    end
    if (w_load) begin
      w_state   = SETUP;
      w_step    = w_ld_step;
      w_psel    = 1'b1;
      w_penable = 1'b0;
      w_pwrite  = (w_ld_step != ST_RD);
      w_pstrb   = (w_ld_step != ST_RD) ? 4'hf : 4'h0;
      w_paddr   = BASE_ADDR | {20'h0, f_ofs(w_ld_step)};
      w_pwdata  = f_data(w_ld_step, w_ld_inst, w_ld_wdata);
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state     <= IDLE;
      r_step      <= '0;
      r_todo      <= '0;
      r_inst      <= '0;
      r_wdata     <= '0;
      r_en_done   <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pstrb     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state;
      r_step      <= w_step;
      r_todo      <= w_todo;
      r_inst      <= w_inst;
      r_wdata     <= w_wdata;
      r_en_done   <= w_en_done;
      r_psel      <= w_psel;
      r_penable   <= w_penable;
      r_pwrite    <= w_pwrite;
      r_paddr     <= w_paddr;
      r_pstrb     <= w_pstrb;
      r_pwdata    <= w_pwdata;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
      r_rsp_rdata <= w_rsp_rdata;
    end
  end

  assign cmd_ready = (r_state == IDLE) && presetn;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pstrb     = r_pstrb;
  assign pwdata    = r_pwdata;

endmodule

// File: doc/dbgapb_mst.md
# dbgapb_mst

APB initiator that drives the CPU debug APB slave on behalf of a host-side debug transport (JTAG/UART bridge). Accepts one debug command per handshake: a 32-bit debug instruction word plus optional write data and optional read-back. Expands it into the required sequence of APB transfers to the debug register window and returns read data and error status on a response handshake. Sits between the debug transport and the debug APB port of the CPU.

## Interface
- BASE_ADDR, 32'h0000_0000: base of the debug register window; paddr = BASE_ADDR | offset.
- OFS_DBG_EN / OFS_INST / OFS_INST_WR / OFS_WDATA / OFS_WDATA_WR / OFS_RDATA, 12'h000 / 12'h004 / 12'h008 / 12'h00c / 12'h010 / 12'h014: register offsets.
- TIMEOUT, 1023: maximum access-phase wait cycles (used only with the timeout feature).

Ports:
- pclk  in  1  clock; single clock domain.
- presetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_inst  in  32  debug instruction word (opcode [11:0], operand [27:16]).
- cmd_wdata  in  32  data staged before the instruction.
- cmd_wr  in  1  stage cmd_wdata before issuing the instruction.
- cmd_rd  in  1  read the RDATA register after the instruction.
- rsp_valid  out  1  response available; held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  RDATA value; 0 when cmd_rd=0 or on error.
- rsp_err  out  1  transfer error (pslverr or timeout).
- psel, penable, pwrite  out  1  APB control.
- paddr  out  32  APB address.
- pstrb  out  4  4'hf on writes, 4'h0 on reads.
- pwdata  out  32  APB write data.
- prdata  in  32  APB read data.
- pready, pslverr  in  1  APB completion and error.

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- cmd_ready = (state==IDLE). Acceptance latches cmd_inst, cmd_wdata, cmd_wr, cmd_rd and builds the step list, then enters SETUP at the first step.
- Step order, with skipped steps omitted:
  1. EN: write 1 to OFS_DBG_EN, only if the internal en_done flag is 0.
  2. WDATA: write cmd_wdata, only if cmd_wr.
  3. WDATA_WR: write 1, only if cmd_wr.
  4. INST: write cmd_inst.
  5. INST_WR: write 1.
  6. RDATA: read, only if cmd_rd.
- en_done is set when the EN write completes without error. It is cleared only by reset.
- SETUP: psel=1, penable=0, with paddr, pwrite, pwdata and pstrb valid. Always 1 cycle, then ACCESS.
- ACCESS: psel=1, penable=1, signals held. Waits while pready=0.
  - On pready=1 and pslverr=1: abort the remaining steps, set rsp_err=1 and rsp_rdata=0, go to RESP.
  - On pready=1 at the RDATA step: capture prdata into rsp_rdata.
  - On pready=1 otherwise: go to SETUP of the next step, or to RESP after the last step.
- RESP: rsp_valid=1; rsp_rdata and rsp_err held stable. Returns to IDLE on rsp_ready.
- psel and penable are 0 in IDLE and RESP. paddr, pwdata and pstrb are don't-care there but held at their last values.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values and en_done=0. The command in flight is lost.

## Timing
- Reset values: cmd_ready=0 while presetn is low, then 1 in IDLE. rsp_valid=0, rsp_rdata=0, rsp_err=0, psel=0, penable=0, pwrite=0, paddr=0, pstrb=0, pwdata=0.
- Every APB output is registered. Each transfer takes 2 cycles plus its pready wait cycles, with no idle cycles between consecutive transfers.
- rsp_valid rises in the cycle after the final ACCESS completes.
- Latency from acceptance to rsp_valid is 2×(number of steps)+(total wait cycles)+1.
- cmd_valid while not IDLE is ignored; cmd_* may change freely.
- rsp_valid and rsp_ready high in the same cycle: IDLE next cycle and cmd_ready=1.

## Configuration
- DBGAPB_MST_TIMEOUT_EN defined: a 10-bit counter counts ACCESS cycles with pready=0.
  - Reaching TIMEOUT aborts the command: psel and penable drop in the next cycle, rsp_err=1, RESP.
  - The counter clears on every SETUP.
- Undefined: no counter; ACCESS waits indefinitely for pready.

## Test plan
- Status read on a fresh reset (cmd_inst=INST_STATUS_RD, cmd_rd=1, slave pready always 1): EN, INST, INST_WR and RDATA transfers at offsets 0x000, 0x004, 0x008 and 0x014, with the EN transfer carrying pwdata=1. rsp_valid 9 cycles after acceptance; rsp_rdata equals the slave value.
- Second command (cmd_wr=1, cmd_wdata=32'hdead_beef, no read): no EN step. WDATA (pwdata=32'hdead_beef), WDATA_WR, INST and INST_WR transfers. rsp_err=0, rsp_rdata=0.
- Slave holds pready=0 for 5 cycles on INST_WR: penable stays high for 6 cycles with all signals stable. Latency grows by 5.
- pslverr=1 on the WDATA step: no further psel. rsp_err=1, rsp_rdata=0, en_done unchanged.
- rsp_ready held low for 10 cycles: rsp_valid and data stable, cmd_ready=0, and a cmd_valid pulse is not accepted.
- With DBGAPB_MST_TIMEOUT_EN and TIMEOUT=16, pready stuck at 0: abort after 16 wait cycles with rsp_err=1. A presetn pulse mid-access returns all outputs to 0 asynchronously.
